// File: rtl/sobel_window_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sobel_window_ctrl: streams a frame through a 3x3 Sobel window (read/write)   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sobel_window_ctrl #(
  parameter int         IMG_W    = 8,
  parameter int         IMG_H    = 8,
  parameter logic [7:0] SRC_BASE = 8'h00,
  parameter logic [7:0] DST_BASE = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       read_data_done,
  input  logic [7:0] data_r_o,
  input  logic       write_done,
  output logic       start_read,
  output logic [7:0] addr_r_mc,
  output logic       start_write,
  output logic [7:0] addr_w_mc,
  output logic [7:0] data_w,
  output logic       active,
  output logic       frame_done
);

  localparam logic [4:0] C_LAST = 5'(IMG_W - 1);
  localparam logic [4:0] R_LAST = 5'(IMG_H - 3);

  typedef enum logic [2:0] {IDLE, READ, COMPUTE, WRITE, DONE} state_t;

  state_t     state_q;
  logic [4:0] r_q, c_q;
  logic [1:0] k_q;
  logic [7:0] col_q [2];
  logic [7:0] win_q [3][3];
  logic       start_read_q, start_write_q, active_q, frame_done_q;
  logic [7:0] addr_r_q, addr_w_q, data_w_q;

  logic signed [11:0] gx_d, gy_d;
  logic [10:0]        ax_d, ay_d, sum_d;
  logic [7:0]         mag_d;

  function automatic logic [7:0] src_addr(input logic [4:0] row, input logic [4:0] col);
    int t;
    t = int'(SRC_BASE) + int'(row) * IMG_W + int'(col);
    return t[7:0];
  endfunction

  function automatic logic [7:0] dst_addr(input logic [4:0] row, input logic [4:0] col);
    int t;
    t = int'(DST_BASE) + int'(row) * (IMG_W - 2) + int'(col) - 2;
    return t[7:0];
  endfunction

  function automatic logic signed [11:0] ext(input logic [7:0] v);
    return signed'({4'b0000, v});
  endfunction

  // Magnitude is bounded by 2040, so 11 bits hold |Gx|+|Gy| before saturation.
  always_comb begin
    gx_d  = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
          - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    gy_d  = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
          - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
    ax_d  = gx_d[11] ? 11'(-gx_d) : 11'(gx_d);
    ay_d  = gy_d[11] ? 11'(-gy_d) : 11'(gy_d);
    sum_d = ax_d + ay_d;
    mag_d = (sum_d > 11'd255) ? 8'hFF : sum_d[7:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      r_q           <= '0;
      c_q           <= '0;
      k_q           <= '0;
      col_q[0]      <= '0;
      col_q[1]      <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_q[i][j] <= '0;
      start_read_q  <= 1'b0;
      start_write_q <= 1'b0;
      active_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      addr_r_q      <= '0;
      addr_w_q      <= '0;
      data_w_q      <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            r_q          <= '0;
            c_q          <= '0;
            k_q          <= '0;
            active_q     <= 1'b1;
            start_read_q <= 1'b1;
            addr_r_q     <= src_addr(5'd0, 5'd0);
            state_q      <= READ;
          end
        end
        READ: begin
          if (read_data_done) begin
            if (k_q != 2'd2) begin
              if (k_q == 2'd0) col_q[0] <= data_r_o;
              else             col_q[1] <= data_r_o;
              k_q      <= k_q + 2'd1;
              addr_r_q <= src_addr(r_q + 5'(k_q) + 5'd1, c_q);
            end else begin
              for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
              end
              win_q[0][2] <= col_q[0];
              win_q[1][2] <= col_q[1];
              win_q[2][2] <= data_r_o;
              k_q         <= '0;
              if (c_q < 5'd2) begin
                c_q      <= c_q + 5'd1;
                addr_r_q <= src_addr(r_q, c_q + 5'd1);
              end else begin
                start_read_q <= 1'b0;
                state_q      <= COMPUTE;
              end
            end
          end
        end
        COMPUTE: begin
          data_w_q      <= mag_d;
          addr_w_q      <= dst_addr(r_q, c_q);
          start_write_q <= 1'b1;
          state_q       <= WRITE;
        end
        WRITE: begin
          if (write_done) begin
            start_write_q <= 1'b0;
            if (c_q < C_LAST) begin
              c_q          <= c_q + 5'd1;
              start_read_q <= 1'b1;
              addr_r_q     <= src_addr(r_q, c_q + 5'd1);
              state_q      <= READ;
            end else if (r_q < R_LAST) begin
              r_q          <= r_q + 5'd1;
              c_q          <= '0;
              for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                  win_q[i][j] <= '0;
              start_read_q <= 1'b1;
              addr_r_q     <= src_addr(r_q + 5'd1, 5'd0);
              state_q      <= READ;
            end else begin
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_read  = start_read_q;
  assign addr_r_mc   = addr_r_q;
  assign start_write = start_write_q;
  assign addr_w_mc   = addr_w_q;
  assign data_w      = data_w_q;
  assign active      = active_q;
  assign frame_done  = frame_done_q;

endmodule
`default_nettype wire
